i2c_master_byte: RTL

Single-master I2C controller that performs one complete one-byte transaction per request: START, 7-bit address plus R/W, subordinate ACK, one data byte written or read, the ninth-bit acknowledge, then STOP. It is the initiator counterpart to the one-byte I2C subordinate in the same `for_one_byte` design. It generates SCL from the system clock, drives SDA open-drain, and reports the read byte and acknowledge status to local logic.

---
 rtl/i2c_master_byte.sv | 186 ++++++++++++++++++
 1 files changed

// File: rtl/i2c_master_byte.sv
// Single-master I2C controller: one START/address/byte/acknowledge/STOP transaction per request.
// SCL is generated from clk_400 in quarter-period steps; SDA is open-drain (drives 0 or z only).
module i2c_master_byte #(
    parameter int unsigned QTR = 4
) (
    input  logic       clk_400,
    input  logic       rst_n,
    input  logic       start,
    input  logic [6:0] addr,
    input  logic       rw,
    input  logic [7:0] data_wr,
    output logic [7:0] data_rd,
    output logic       busy,
    output logic       done,
    output logic       ack_error,
    output logic       SCL,
    inout  wire        SDA
);

    localparam int unsigned QW = (QTR > 1) ? $clog2(QTR) : 1;

    typedef enum logic [3:0] {
        StIdle,
        StStart,
        StAddr,
        StAddrAck,
        StWriteData,
        StWriteAck,
        StReadData,
        StMasterNack,
        StStop
    } state_t;

    state_t          r_state, w_state_nxt;
    logic [QW-1:0]   r_qcnt, w_qcnt_nxt;
    logic [1:0]      r_phase, w_phase_nxt;
    logic [2:0]      r_bitcnt, w_bitcnt_nxt;
    logic [7:0]      r_shift, w_shift_nxt;
    logic [7:0]      r_data_wr, w_data_wr_nxt;
    logic [7:0]      r_rx, w_rx_nxt;
    logic [7:0]      r_data_rd, w_data_rd_nxt;
    logic            r_rw, w_rw_nxt;
    logic            r_done, w_done_nxt;
    logic            r_ack_error, w_ack_error_nxt;

    logic            w_q_end, w_sample, w_slot_end, w_multi_bit;
    logic            w_scl, w_sda_oe;

    assign w_q_end     = (r_qcnt == QW'(QTR - 1));
    assign w_sample    = w_q_end && (r_phase == 2'd2);
    assign w_slot_end  = w_q_end && (r_phase == 2'd3);
    assign w_multi_bit = (r_state == StAddr) || (r_state == StWriteData) ||
                         (r_state == StReadData);

    always_ff @(posedge clk_400 or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= StIdle;
            r_qcnt      <= '0;
            r_phase     <= 2'd0;
            r_bitcnt    <= 3'd0;
            r_shift     <= 8'h00;
            r_data_wr   <= 8'h00;
            r_rx        <= 8'h00;
            r_data_rd   <= 8'h00;
            r_rw        <= 1'b0;
            r_done      <= 1'b0;
            r_ack_error <= 1'b0;
        end else begin
            r_state     <= w_state_nxt;
            r_qcnt      <= w_qcnt_nxt;
            r_phase     <= w_phase_nxt;
            r_bitcnt    <= w_bitcnt_nxt;
            r_shift     <= w_shift_nxt;
            r_data_wr   <= w_data_wr_nxt;
            r_rx        <= w_rx_nxt;
            r_data_rd   <= w_data_rd_nxt;
            r_rw        <= w_rw_nxt;
            r_done      <= w_done_nxt;
            r_ack_error <= w_ack_error_nxt;
        end
    end

    always_comb begin
        w_state_nxt     = r_state;
        w_qcnt_nxt      = r_qcnt;
        w_phase_nxt     = r_phase;
        w_bitcnt_nxt    = r_bitcnt;
        w_shift_nxt     = r_shift;
        w_data_wr_nxt   = r_data_wr;
        w_rx_nxt        = r_rx;
        w_data_rd_nxt   = r_data_rd;
        w_rw_nxt        = r_rw;
        w_done_nxt      = 1'b0;
        w_ack_error_nxt = r_ack_error;
        w_scl           = 1'b1;
        w_sda_oe        = 1'b0;

        // Counters free-run during a transaction and wrap back to zero at the final slot end.
        if (r_state != StIdle) begin
            w_qcnt_nxt = w_q_end ? '0 : QW'(r_qcnt + 1'b1);
            if (w_q_end) w_phase_nxt = r_phase + 2'd1;
            if (w_slot_end && w_multi_bit) w_bitcnt_nxt = r_bitcnt + 3'd1;
        end

        case (r_state)
            StIdle: begin
                // The done cycle is excluded so a held start cannot retrigger immediately.
                if (start && !r_done) begin
                    w_state_nxt     = StStart;
                    w_shift_nxt     = {addr, rw};
                    w_rw_nxt        = rw;
                    w_data_wr_nxt   = data_wr;
                    w_ack_error_nxt = 1'b0;
                end
            end
            StStart: begin
                w_sda_oe = r_phase[1];
                if (w_slot_end) w_state_nxt = StAddr;
            end
            StAddr: begin
                w_scl    = r_phase[1];
                w_sda_oe = !r_shift[7];
                if (w_slot_end) begin
                    w_shift_nxt = {r_shift[6:0], 1'b0};
                    if (r_bitcnt == 3'd7) w_state_nxt = StAddrAck;
                end
            end
            StAddrAck: begin
                w_scl = r_phase[1];
                if (w_sample && SDA) w_ack_error_nxt = 1'b1;
                if (w_slot_end) begin
                    if (r_ack_error) begin
                        w_state_nxt = StStop;
                    end else if (r_rw) begin
                        w_state_nxt = StReadData;
                    end else begin
                        w_state_nxt = StWriteData;
                        w_shift_nxt = r_data_wr;
                    end
                end
            end
            StWriteData: begin
                w_scl    = r_phase[1];
                w_sda_oe = !r_shift[7];
                if (w_slot_end) begin
                    w_shift_nxt = {r_shift[6:0], 1'b0};
                    if (r_bitcnt == 3'd7) w_state_nxt = StWriteAck;
                end
            end
            StWriteAck: begin
                w_scl = r_phase[1];
                if (w_sample && SDA) w_ack_error_nxt = 1'b1;
                if (w_slot_end) w_state_nxt = StStop;
            end
            StReadData: begin
                w_scl = r_phase[1];
                if (w_sample) w_rx_nxt = {r_rx[6:0], SDA};
                if (w_slot_end && (r_bitcnt == 3'd7)) w_state_nxt = StMasterNack;
            end
            StMasterNack: begin
                w_scl = r_phase[1];
                if (w_slot_end) begin
                    w_state_nxt   = StStop;
                    w_data_rd_nxt = r_rx;
                end
            end
            StStop: begin
                w_scl    = r_phase[1];
                w_sda_oe = (r_phase != 2'd3);
                if (w_slot_end) begin
                    w_state_nxt = StIdle;
                    w_done_nxt  = 1'b1;
                end
            end
            default: w_state_nxt = StIdle;
        endcase
    end

    assign SCL       = w_scl;
    assign SDA       = w_sda_oe ? 1'b0 : 1'bz;
    assign busy      = (r_state != StIdle);
    assign done      = r_done;
    assign ack_error = r_ack_error;
    assign data_rd   = r_data_rd;

endmodule
